// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine game controller.
// Credit arithmetic helpers saturate in one extra bit of headroom.
package slot_pkg;

  typedef enum logic [1:0] {IDLE, SPIN, EVAL, HOLD} state_t;
  typedef logic [1:0] symbol_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          CREDIT_W  = 10;

  function automatic logic [CREDIT_W-1:0] sat_add(
    input logic [CREDIT_W-1:0] a,
    input logic [CREDIT_W-1:0] b,
    input logic [CREDIT_W-1:0] lim
  );
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/slot_lfsr.sv
// 16-bit Galois LFSR, exposes its low OUT_W bits; steps once per enabled cycle.
// Latency: new value visible one cycle after the enabled edge; no backpressure.
module slot_lfsr
  import slot_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] rnd
);

  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign rnd = lfsr[OUT_W-1:0];

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot machine game FSM: button edges and frame ticks in, reel/credit/bet/win state out.
// Latency: button press acts one cycle after the rising level; no backpressure, presses while busy are dropped.
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter logic [CREDIT_W-1:0] START_CREDIT   = 10'd100,
  parameter logic [CREDIT_W-1:0] MAX_CREDIT     = 10'd999,
  parameter logic [CREDIT_W-1:0] COIN_VALUE     = 10'd10,
  parameter logic [7:0]          SPIN_FRAMES    = 8'd60,
  parameter logic [7:0]          STAGGER_FRAMES = 8'd30,
  parameter logic [7:0]          HOLD_FRAMES    = 8'd60,
  parameter logic [3:0]          PAYOUT_3       = 4'd10,
  parameter logic [3:0]          PAYOUT_2       = 4'd2,
  parameter logic [15:0]         LFSR_SEED      = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_spin,
  input  logic                btn_bet,
  input  logic                btn_coin,
  input  logic                frame_tick,
  output logic [1:0]          reel0,
  output logic [1:0]          reel1,
  output logic [1:0]          reel2,
  output logic [2:0]          reel_stop,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          bet,
  output logic                win,
  output logic                busy
);

  state_t              state;
  logic [7:0]          frame_cnt;
  logic [7:0]          cnt_inc;
  logic [5:0]          rnd_q;
  logic [5:0]          lfsr_rnd;
  logic                prev_spin, prev_bet, prev_coin;
  logic                press_spin, press_bet, press_coin;
  symbol_t             reels [3];
  logic [7:0]          stop_t [3];
  logic [2:0]          stop_nxt;
  logic [CREDIT_W-1:0] bet_ext;
  logic [CREDIT_W-1:0] pay;
  logic                eq01, eq12, eq02;

  slot_lfsr #(.SEED(LFSR_SEED), .OUT_W(6)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .rnd (lfsr_rnd)
  );

  always_ff @(posedge clk) begin
    prev_spin <= btn_spin;
    prev_bet  <= btn_bet;
    prev_coin <= btn_coin;
  end

  assign press_spin = btn_spin & ~prev_spin;
  assign press_bet  = btn_bet  & ~prev_bet;
  assign press_coin = btn_coin & ~prev_coin;
  assign bet_ext    = {{(CREDIT_W-2){1'b0}}, bet};

  // Each reel stops on the tick whose post-increment count hits its target.
  always_comb begin
    cnt_inc   = frame_cnt + 8'd1;
    stop_t[0] = SPIN_FRAMES + {6'd0, rnd_q[1:0]};
    stop_t[1] = SPIN_FRAMES + STAGGER_FRAMES + {6'd0, rnd_q[3:2]};
    stop_t[2] = SPIN_FRAMES + (STAGGER_FRAMES << 1) + {6'd0, rnd_q[5:4]};
    stop_nxt  = reel_stop;
    for (int i = 0; i < 3; i++) begin
      if (cnt_inc == stop_t[i]) stop_nxt[i] = 1'b1;
    end
  end

  assign eq01 = (reels[0] == reels[1]);
  assign eq12 = (reels[1] == reels[2]);
  assign eq02 = (reels[0] == reels[2]);

  always_comb begin
    pay = '0;
    if (eq01 && eq12) begin
      pay = bet_ext * {{(CREDIT_W-4){1'b0}}, PAYOUT_3};
    end else if (eq01 || eq12 || eq02) begin
      pay = bet_ext * {{(CREDIT_W-4){1'b0}}, PAYOUT_2};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      rnd_q     <= '0;
      credit    <= START_CREDIT;
      bet       <= 2'd1;
      reel_stop <= 3'b111;
      win       <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < 3; i++) reels[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press_spin) begin
            if (credit >= bet_ext) begin
              credit    <= credit - bet_ext;
              win       <= 1'b0;
              reel_stop <= 3'b000;
              frame_cnt <= '0;
              rnd_q     <= lfsr_rnd;
              busy      <= 1'b1;
              state     <= SPIN;
            end
          end else if (press_bet) begin
            bet <= (bet == 2'd3) ? 2'd1 : bet + 2'd1;
          end else if (press_coin) begin
            credit <= sat_add(credit, COIN_VALUE, MAX_CREDIT);
          end
        end
        SPIN: begin
          if (frame_tick) begin
            frame_cnt <= cnt_inc;
            reel_stop <= stop_nxt;
            for (int i = 0; i < 3; i++) begin
              if (!reel_stop[i]) reels[i] <= reels[i] + 2'd1;
            end
            if (stop_nxt == 3'b111) state <= EVAL;
          end
        end
        EVAL: begin
          credit    <= sat_add(credit, pay, MAX_CREDIT);
          win       <= (pay != '0);
          frame_cnt <= '0;
          state     <= HOLD;
        end
        HOLD: begin
          if (frame_tick) begin
            frame_cnt <= cnt_inc;
            if (cnt_inc == HOLD_FRAMES) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign reel0 = reels[0];
  assign reel1 = reels[1];
  assign reel2 = reels[2];

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Randomized scoreboard bench for slot_game_ctrl: a transaction-level game model
// predicts every visible state change; a monitor pops and compares on each change.
module tb_slot_game_ctrl;

  typedef struct packed {
    logic [9:0] credit;
    logic [1:0] bet;
    logic [1:0] r0, r1, r2;
    logic [2:0] stop;
    logic       win;
    logic       busy;
  } snap_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic       btn_spin = 1'b0, btn_bet = 1'b0, btn_coin = 1'b0, frame_tick = 1'b0;
  logic [1:0] reel0, reel1, reel2, bet;
  logic [2:0] reel_stop;
  logic [9:0] credit;
  logic       win, busy;

  logic       lo_spin = 1'b0, lo_bet_btn = 1'b0;
  logic [1:0] lo_r0, lo_r1, lo_r2, lo_bet;
  logic [2:0] lo_stop;
  logic [9:0] lo_credit;
  logic       lo_win, lo_busy;

  slot_game_ctrl u_dut (
    .clk(clk), .rst(rst), .btn_spin(btn_spin), .btn_bet(btn_bet), .btn_coin(btn_coin),
    .frame_tick(frame_tick), .reel0(reel0), .reel1(reel1), .reel2(reel2),
    .reel_stop(reel_stop), .credit(credit), .bet(bet), .win(win), .busy(busy)
  );

  slot_game_ctrl #(.START_CREDIT(10'd2)) u_low (
    .clk(clk), .rst(rst), .btn_spin(lo_spin), .btn_bet(lo_bet_btn), .btn_coin(1'b0),
    .frame_tick(1'b0), .reel0(lo_r0), .reel1(lo_r1), .reel2(lo_r2),
    .reel_stop(lo_stop), .credit(lo_credit), .bet(lo_bet), .win(lo_win), .busy(lo_busy)
  );

  always #5 clk = ~clk;

  int    checks = 0, errors = 0;
  snap_t exp_q[$];
  bit    mon_en = 1'b0;
  snap_t prev_s, cur_s;

  // Game model state
  int       m_credit, m_bet;
  int       m_reel[3];
  bit [2:0] m_stop;
  bit       m_win, m_busy;
  logic [15:0] m_lfsr;

  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic snap_t dut_snap();
    snap_t s;
    s.credit = credit; s.bet = bet; s.r0 = reel0; s.r1 = reel1; s.r2 = reel2;
    s.stop = reel_stop; s.win = win; s.busy = busy;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.credit = 10'(m_credit); s.bet = 2'(m_bet);
    s.r0 = 2'(m_reel[0]); s.r1 = 2'(m_reel[1]); s.r2 = 2'(m_reel[2]);
    s.stop = m_stop; s.win = m_win; s.busy = m_busy;
    return s;
  endfunction

  function automatic logic [16:0] trig(snap_t s);
    return {s.credit, s.bet, s.stop, s.win, s.busy};
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("credit=%0d bet=%0d reels=%0d/%0d/%0d stop=%b win=%0d busy=%0d",
                     s.credit, s.bet, s.r0, s.r1, s.r2, s.stop, s.win, s.busy);
  endfunction

  task automatic check_snap(input string name, input snap_t got, input snap_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %s, want %s", name, fmt(got), fmt(want));
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_now(input string name);
    check_snap(name, dut_snap(), model_snap());
  endtask

  // Monitor: every change of the event-type outputs must match the next prediction.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      cur_s = dut_snap();
      if (trig(cur_s) != trig(prev_s)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_change: got %s, want unchanged %s", fmt(cur_s), fmt(prev_s));
        end else begin
          check_snap("event", cur_s, exp_q.pop_front());
        end
      end
      prev_s = cur_s;
    end
  end

  task automatic push();
    exp_q.push_back(model_snap());
  endtask

  task automatic model_reset();
    m_credit = 100; m_bet = 1; m_reel = '{0, 0, 0};
    m_stop = 3'b111; m_win = 1'b0; m_busy = 1'b0;
  endtask

  task automatic idle_cycle(input bit spin_lvl, input bit tick);
    btn_spin = spin_lvl; btn_bet = 1'b0; btn_coin = 1'b0; frame_tick = tick;
    @(negedge clk);
  endtask

  task automatic run_spin(input int rnd, input int period, input int hold, input int rst_at);
    int       t[3];
    int       k, pay, nc;
    bit [2:0] old;
    for (int i = 0; i < 3; i++) t[i] = 60 + 30 * i + ((rnd >> (2 * i)) & 3);
    k = 0;
    while (m_stop != 3'b111) begin
      repeat (period - 1) begin idle_cycle(hold > 0, 1'b0); hold--; end
      k++;
      old = m_stop;
      for (int i = 0; i < 3; i++) begin
        if (!m_stop[i]) begin
          m_reel[i] = (m_reel[i] + 1) % 4;
          if (k == t[i]) m_stop[i] = 1'b1;
        end
      end
      if (m_stop != old) push();
      idle_cycle(hold > 0, 1'b1); hold--;
      if (k == rst_at) begin
        rst = 1'b1; model_reset(); push();
        idle_cycle(1'b0, 1'b0);
        rst = 1'b0;
        return;
      end
    end
    if (m_reel[0] == m_reel[1] && m_reel[1] == m_reel[2]) pay = m_bet * 10;
    else if (m_reel[0] == m_reel[1] || m_reel[1] == m_reel[2] || m_reel[0] == m_reel[2]) pay = m_bet * 2;
    else pay = 0;
    if (pay > 0) begin
      nc = m_credit + pay;
      m_credit = (nc > 999) ? 999 : nc;
      m_win = 1'b1;
      push();
    end
    for (int h = 1; h <= 60; h++) begin
      repeat (period - 1) begin idle_cycle(hold > 0, 1'b0); hold--; end
      if (h == 60) begin m_busy = 1'b0; push(); end
      idle_cycle(hold > 0, 1'b1); hold--;
    end
    idle_cycle(1'b0, 1'b0);
  endtask

  // m: bit0 spin, bit1 bet, bit2 coin; all presses land on the same edge.
  task automatic press(input logic [2:0] m, input int period, input int hold, input int rst_at);
    int rnd, nc;
    bit acc;
    rnd = int'(m_lfsr[5:0]);
    btn_spin = m[0]; btn_bet = m[1]; btn_coin = m[2]; frame_tick = 1'b0;
    acc = m[0] && (m_credit >= m_bet);
    if (m[0]) begin
      if (acc) begin
        m_credit -= m_bet; m_win = 1'b0; m_stop = 3'b000; m_busy = 1'b1;
        push();
      end
    end else if (m[1]) begin
      m_bet = (m_bet == 3) ? 1 : m_bet + 1;
      push();
    end else if (m[2]) begin
      nc = (m_credit + 10 > 999) ? 999 : m_credit + 10;
      if (nc != m_credit) begin m_credit = nc; push(); end
    end
    @(negedge clk);
    btn_bet = 1'b0; btn_coin = 1'b0;
    if (acc) run_spin(rnd, period, hold - 1, rst_at);
    else idle_cycle(1'b0, 1'b0);
  endtask

  task automatic wait_rnd(input logic [5:0] target);
    int n;
    n = 0;
    while (m_lfsr[5:0] != target && n < 5000) begin idle_cycle(1'b0, 1'b0); n++; end
    if (m_lfsr[5:0] != target) begin
      checks++; errors++;
      $display("FAIL wait_rnd: got lfsr low bits %0d, want %0d", m_lfsr[5:0], target);
    end
  endtask

  task automatic lo_press(input bit s, input bit b);
    lo_spin = s; lo_bet_btn = b;
    @(negedge clk);
    lo_spin = 1'b0; lo_bet_btn = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    checks++; errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] m;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    prev_s = model_snap();
    mon_en = 1'b1;
    repeat (10) idle_cycle(1'b0, 1'b0);
    check_now("reset_state");

    // Low-credit instance: spin refused while credit < bet.
    lo_press(1'b0, 1'b1);
    lo_press(1'b0, 1'b1);
    check_val("lo_bet3", int'(lo_bet), 3);
    lo_press(1'b1, 1'b0);
    check_val("lo_refused_credit", int'(lo_credit), 2);
    check_val("lo_refused_busy", int'(lo_busy), 0);
    check_val("lo_refused_stop", int'(lo_stop), 7);
    check_val("lo_reels", int'({lo_r0, lo_r1, lo_r2, lo_win}), 0);
    lo_press(1'b0, 1'b1);
    lo_press(1'b1, 1'b0);
    check_val("lo_accept_credit", int'(lo_credit), 1);
    check_val("lo_accept_busy", int'(lo_busy), 1);

    // Bet cycling and coin saturation.
    repeat (3) press(3'b010, 2, 1, 0);
    check_now("bet_wrap");
    press(3'b100, 2, 1, 0);
    check_now("coin_once");
    repeat (90) press(3'b100, 2, 1, 0);
    check_now("coin_saturated");

    // Spins with known stop offsets.
    wait_rnd(6'b000000);
    press(3'b001, 10, 1, 0);
    check_now("spin_rnd0");
    wait_rnd(6'b101000);
    press(3'b001, 10, 1, 0);
    check_now("spin_rnd28");

    // Spin and bet together: spin wins, bet unchanged.
    press(3'b011, 3, 1, 0);
    check_now("spin_over_bet");

    // Reset mid-spin, then a held spin button.
    press(3'b001, 3, 1, 75);
    repeat (3) idle_cycle(1'b0, 1'b0);
    check_now("reset_mid_spin");
    press(3'b001, 10, 500, 0);
    repeat (5) idle_cycle(1'b0, 1'b0);
    check_now("held_spin_once");

    for (int n = 0; n < 24; n++) begin
      m = 3'($urandom_range(1, 7));
      repeat ($urandom_range(0, 3)) idle_cycle(1'b0, 1'b0);
      press(m, $urandom_range(2, 5), 1, 0);
    end
    repeat (5) idle_cycle(1'b0, 1'b0);
    check_now("final_state");
    check_val("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
